// File: rtl/instr_feeder.sv
// Instruction feeder: holds a small program in registers and steps it into a
// processor one word at a time, handling two-word mvi instructions and timeouts.
module instr_feeder #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    input  logic              done,
    output logic [15:0]       DIN,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              finished,
    output logic              error
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, IMM, WAIT_DONE, NEXT} state_t;

    state_t            state, state_nx;
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W:0]   pc_q, pc_nx;
    logic [CW-1:0]     tcnt, tcnt_nx;
    logic              finished_nx, error_nx;
    logic [ADDR_W-1:0] pc_idx;
    logic [15:0]       cur_word, imm_word;
    logic              is_mvi, last_word;

    assign pc_idx    = pc_q[ADDR_W-1:0];
    assign cur_word  = mem[pc_idx];
    assign imm_word  = mem[pc_idx + ADDR_W'(1)];
    assign is_mvi    = (cur_word[8:6] == 3'b001);
    assign last_word = (pc_q + (ADDR_W+1)'(1) == prog_len) || (pc_idx == '1);

    // NOTE: the program store must clear on reset, so it is built from flops
    // with a reset loop; a RAM macro could not be inferred from this.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc_q     <= '0;
            tcnt     <= '0;
            finished <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_q     <= pc_nx;
            tcnt     <= tcnt_nx;
            finished <= finished_nx;
            error    <= error_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        pc_nx       = pc_q;
        tcnt_nx     = tcnt;
        finished_nx = finished;
        error_nx    = error;
        case (state)
            IDLE: begin
                if (start) begin
                    finished_nx = 1'b0;
                    error_nx    = 1'b0;
                    pc_nx       = '0;
                    state_nx    = NEXT;
                end
            end
            NEXT: begin
                if (pc_q >= prog_len) begin
                    finished_nx = 1'b1;
                    state_nx    = IDLE;
                end else begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                tcnt_nx = '0;
                // An mvi whose immediate would lie past the program is fatal.
                if (is_mvi && last_word) begin
                    error_nx = 1'b1;
                    state_nx = IDLE;
                end else if (is_mvi) begin
                    state_nx = IMM;
                end else begin
                    state_nx = WAIT_DONE;
                end
            end
            IMM, WAIT_DONE: begin
                if (done) begin
                    pc_nx    = pc_q + (ADDR_W+1)'(is_mvi ? 2 : 1);
                    state_nx = NEXT;
                end else if (tcnt == CW'(TIMEOUT - 1)) begin
                    error_nx = 1'b1;
                    state_nx = IDLE;
                end else begin
                    tcnt_nx = tcnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign run  = (state == ISSUE);
    assign busy = (state != IDLE);
    assign DIN  = (state == IMM) ? imm_word : cur_word;
    assign pc   = pc_idx;

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: normal mvi program, empty program, bad mvi,
// timeout, blocked loads while busy, and reset in the middle of a program.
module tb_instr_feeder;

    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic [ADDR_W:0]   prog_len;
    logic              start;
    logic              done;
    logic [15:0]       DIN;
    logic              run;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              finished;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;
    int run_cnt  = 0;
    int run_base;

    instr_feeder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .start(start), .done(done),
        .DIN(DIN), .run(run), .pc(pc), .busy(busy), .finished(finished), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (run) run_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic kick(input logic [ADDR_W:0] len);
        prog_len = len;
        run_base = run_cnt;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        prog_len = '0; start = 1'b0; done = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_run", run, 0);
        check("rst_pc", pc, 0);
        check("rst_din", DIN, 16'h0000);
        check("rst_fin", finished, 0);
        check("rst_err", error, 0);
        reset = 1'b1;
        tick();

        // mvi R1,5 then a plain instruction; a load attempt while busy must be dropped
        load(0, 16'h0048); load(1, 16'h0005); load(2, 16'h0088);
        kick(3);
        check("t1_next_busy", busy, 1);
        check("t1_next_run", run, 0);
        tick();
        check("t1_iss0_run", run, 1);
        check("t1_iss0_din", DIN, 16'h0048);
        check("t1_iss0_pc", pc, 0);
        load_en = 1'b1; load_addr = 0; load_data = 16'hFFFF;
        tick();
        load_en = 1'b0;
        check("t1_imm_din", DIN, 16'h0005);
        check("t1_imm_run", run, 0);
        tick(); done = 1'b1;
        check("t1_wait_run", run, 0);
        tick(); done = 1'b0;
        check("t1_pc2", pc, 2);
        tick();
        check("t1_iss2_run", run, 1);
        check("t1_iss2_din", DIN, 16'h0088);
        tick(); done = 1'b1;
        tick(); done = 1'b0;
        tick();
        check("t1_fin", finished, 1);
        check("t1_busy", busy, 0);
        check("t1_err", error, 0);
        check("t1_runs", run_cnt - run_base, 2);

        // empty program
        kick(0);
        check("t2_fin_clr", finished, 0);
        check("t2_busy", busy, 1);
        tick();
        check("t2_fin", finished, 1);
        check("t2_idle", busy, 0);
        check("t2_runs", run_cnt - run_base, 0);

        // mvi as the last word; also shows mem[0] survived the blocked load
        kick(1);
        tick();
        check("t3_run", run, 1);
        check("t3_mem0", DIN, 16'h0048);
        tick();
        check("t3_err", error, 1);
        check("t3_busy", busy, 0);
        check("t3_run_off", run, 0);
        check("t3_fin", finished, 0);

        // timeout with done never asserted
        load(0, 16'h0010);
        kick(1);
        check("t4_err_clr", error, 0);
        tick();
        tick();
        repeat (TIMEOUT - 1) tick();
        check("t4_pre_busy", busy, 1);
        check("t4_pre_err", error, 0);
        tick();
        check("t4_err", error, 1);
        check("t4_busy", busy, 0);

        // reset while waiting on the second instruction
        load(1, 16'h0020);
        kick(2);
        tick();
        tick(); done = 1'b1;
        tick(); done = 1'b0;
        check("t5_pc1", pc, 1);
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        check("t5_rst_pc", pc, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_run", run, 0);
        check("t5_rst_din", DIN, 16'h0000);
        tick();
        reset = 1'b1;
        run_base = run_cnt;
        repeat (4) tick();
        check("t5_no_run", run_cnt - run_base, 0);
        check("t5_idle", busy, 0);
        load(0, 16'h0088);
        kick(1);
        tick();
        check("t5_re_run", run, 1);
        check("t5_re_pc", pc, 0);
        check("t5_re_din", DIN, 16'h0088);
        tick(); done = 1'b1;
        tick(); done = 1'b0;
        tick();
        check("t5_re_fin", finished, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
